sync_fifo_fwft: RTL and testbench
=================================

Name: sync_fifo_fwft

Overview:
- Single-clock, parametrised successor to the dual-clock Bluespec SyncFIFO wrapper used in the fieldious datapath.
- Buffers DSIZE-bit words between producer and consumer stages in the same clock domain.
- Adds first-word-fall-through output, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags.
- Keeps the Bluespec-style active-high "not full" / "not empty" status so existing control logic ports over unchanged.

Parameters:
- DSIZE, 11, data word width in bits (>=1).
- DEPTH, 16, number of entries; must be a power of two, >=2.
- AFULL_TH, 14, almost_full asserts when count >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1).
- Derived localparams: AW = log2(DEPTH); CW = AW+1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; empties FIFO and clears error flags.
- enq  in  1  write request.
- d_in  in  DSIZE  write data, sampled with enq.
- full_n  out  1  1 = at least one free entry.
- deq  in  1  read/pop request.
- d_out  out  DSIZE  head-of-queue data, valid whenever empty_n=1.
- empty_n  out  1  1 = at least one entry stored.
- count  out  CW  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- overflow  out  1  sticky; set by enq while full_n=0.
- underflow  out  1  sticky; set by deq while empty_n=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr, rd_ptr and count = 0.
  - full_n=1, empty_n=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - Storage contents are not reset; d_out is don't-care while empty_n=0.
- Pointers are AW bits and wrap modulo DEPTH. Full/empty are derived from the count register, not from pointer comparison.
- Accepted write: enq=1 and full_n=1 at a rising edge. mem[wr_ptr] <= d_in; wr_ptr++.
- Accepted read: deq=1 and empty_n=1 at a rising edge. rd_ptr++.
- d_out = mem[rd_ptr], combinational from registered state (FWFT):
  - A word written into an empty FIFO at edge k is on d_out, with empty_n=1, from just after edge k.
  - No extra read latency.
- count update per edge: +1 write only; -1 read only; unchanged when both or neither are accepted.
- All status outputs are combinational decodes of the count register:
  - full_n = (count != DEPTH)
  - empty_n = (count != 0)
- Simultaneous enq and deq:
  - When 0 < count < DEPTH: both accepted; count unchanged; data order preserved.
  - When empty: only the write is accepted; deq is an underflow, so underflow is set and no pop occurs. The new word appears on d_out after the edge.
  - When full: only the read is accepted; enq is an overflow, so overflow is set and the word is dropped. No write-through-on-pop.
- Rejected enq or deq never changes pointers, count or storage.
- clr=1 at an edge overrides enq and deq in that cycle:
  - pointers and count go to 0; overflow and underflow go to 0.
  - Storage contents are untouched.
  - Errors coinciding with clr are not flagged.
- overflow and underflow are cleared only by rst_n or clr.
- Reset asserted mid-operation: all state above returns to its reset value immediately (asynchronously), regardless of clock.
- No parameter checking in RTL beyond a simulation-only elaboration assertion on DEPTH being a power of two and thresholds being in range.

Test Plan:
- Reset/fill: release rst_n, write 16 words 0x001..0x010 back-to-back. Expect:
  - count steps 1..16; full_n drops after the 16th edge.
  - almost_full rises when count reaches 14.
  - empty_n rises after the first edge with d_out=0x001.
- Drain/order: from full, assert deq for 16 cycles. Expect:
  - d_out sequence 0x001..0x010.
  - almost_empty rises at count=2; empty_n falls after the 16th pop; count=0.
- Wrap and concurrency: keep count at 5 with enq and deq both high for 40 cycles on random data. Expect count constant at 5 and output order matching a scoreboard queue across pointer wrap.
- Boundary errors:
  - enq with FIFO full: overflow=1, count stays 16, data dropped.
  - enq+deq with FIFO empty: underflow=1, count=1, d_out equals the written word.
  - Both flags hold until clr.
- Flush: at count=9 with overflow=1, pulse clr together with enq=1. Expect count=0, empty_n=0, overflow=0 next cycle, and the enq is ignored.
- Async reset mid-stream: assert rst_n=0 between clock edges at count=7. Expect count=0, empty_n=0 and full_n=1 before the next edge; normal operation resumes after release.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO with occupancy count,
// programmable almost-full/almost-empty flags, synchronous flush and sticky error flags.
module sync_fifo_fwft #(
  parameter int DSIZE     = 11,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         enq,
  input  logic [DSIZE-1:0]             d_in,
  output logic                         full_n,
  input  logic                         deq,
  output logic [DSIZE-1:0]             d_out,
  output logic                         empty_n,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AFULL_TH < 1) || (AFULL_TH > DEPTH) ||
      (AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_params
    $error("sync_fifo_fwft: DEPTH must be a power of two >= 2 and thresholds in range");
  end
  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow, r_underflow;
  logic             w_wr, w_rd;
  // acceptance is gated by the registered status, so a full FIFO never writes through on a pop
  assign w_wr = enq & full_n;
  assign w_rd = deq & empty_n;
  always_ff @(posedge clk) begin
    if (w_wr && !clr) r_mem[r_wr_ptr] <= d_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd) r_count <= r_count + CW'(1);
      if (w_rd && !w_wr) r_count <= r_count - CW'(1);
      if (enq && !full_n) r_overflow <= 1'b1;
      if (deq && !empty_n) r_underflow <= 1'b1;
    end
  end
  assign d_out        = r_mem[r_rd_ptr];
  assign count        = r_count;
  assign full_n       = r_count != CW'(DEPTH);
  assign empty_n      = r_count != '0;
  assign almost_full  = r_count >= CW'(AFULL_TH);
  assign almost_empty = r_count <= CW'(AEMPTY_TH);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed self-checking bench for sync_fifo_fwft with default parameters.
module tb_sync_fifo_fwft;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        enq = 1'b0;
  logic        deq = 1'b0;
  logic [10:0] d_in = '0;
  logic [10:0] d_out;
  logic        full_n, empty_n, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  count;
  int          n_pass = 0;
  int          n_total = 0;
  logic [10:0] q[$];

  sync_fifo_fwft dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .enq(enq), .d_in(d_in), .full_n(full_n),
    .deq(deq), .d_out(d_out), .empty_n(empty_n), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_total++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (full_n !== 1'b1) $display("FAIL reset_full_n got=%b exp=1", full_n); else n_pass++;
    n_total++; if (empty_n !== 1'b0) $display("FAIL reset_empty_n got=%b exp=0", empty_n); else n_pass++;
    n_total++; if (almost_full !== 1'b0) $display("FAIL reset_afull got=%b exp=0", almost_full); else n_pass++;
    n_total++; if (almost_empty !== 1'b1) $display("FAIL reset_aempty got=%b exp=1", almost_empty); else n_pass++;
    n_total++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_errs got=%b%b exp=00", overflow, underflow); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      enq = 1'b1;
      d_in = 11'(i);
      tick();
      n_total++; if (count !== 5'(i)) $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); else n_pass++;
      n_total++; if (full_n !== (i != 16)) $display("FAIL fill_full_n[%0d] got=%b exp=%b", i, full_n, i != 16); else n_pass++;
      n_total++; if (almost_full !== (i >= 14)) $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, i >= 14); else n_pass++;
      n_total++; if ({empty_n, d_out} !== {1'b1, 11'h001}) $display("FAIL fill_head[%0d] got=%b/%h exp=1/001", i, empty_n, d_out); else n_pass++;
    end
    enq = 1'b0;
  endtask

  task automatic test_overflow();
    enq = 1'b1;
    d_in = 11'h7FF;
    tick();
    enq = 1'b0;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else n_pass++;
    n_total++; if (count !== 5'd16) $display("FAIL ovf_count got=%0d exp=16", count); else n_pass++;
    n_total++; if (d_out !== 11'h001) $display("FAIL ovf_head got=%h exp=001", d_out); else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      n_total++; if (d_out !== 11'(i)) $display("FAIL drain_data[%0d] got=%h exp=%h", i, d_out, 11'(i)); else n_pass++;
      deq = 1'b1;
      tick();
      n_total++; if (count !== 5'(16 - i)) $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 16 - i); else n_pass++;
      n_total++; if (almost_empty !== (16 - i <= 2)) $display("FAIL drain_aempty[%0d] got=%b exp=%b", i, almost_empty, 16 - i <= 2); else n_pass++;
      n_total++; if (empty_n !== (i != 16)) $display("FAIL drain_empty_n[%0d] got=%b exp=%b", i, empty_n, i != 16); else n_pass++;
    end
    deq = 1'b0;
  endtask

  task automatic test_underflow();
    enq = 1'b1;
    deq = 1'b1;
    d_in = 11'h2AA;
    tick();
    enq = 1'b0;
    deq = 1'b0;
    n_total++; if (underflow !== 1'b1) $display("FAIL udf_flag got=%b exp=1", underflow); else n_pass++;
    n_total++; if (count !== 5'd1) $display("FAIL udf_count got=%0d exp=1", count); else n_pass++;
    n_total++; if (d_out !== 11'h2AA) $display("FAIL udf_head got=%h exp=2aa", d_out); else n_pass++;
    tick();
    n_total++; if ({overflow, underflow} !== 2'b11) $display("FAIL errs_sticky got=%b%b exp=11", overflow, underflow); else n_pass++;
    deq = 1'b1;
    tick();
    deq = 1'b0;
    n_total++; if ({overflow, underflow, count} !== {2'b11, 5'd0}) $display("FAIL errs_hold got=%b%b/%0d exp=11/0", overflow, underflow, count); else n_pass++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) begin
      enq = 1'b1;
      d_in = 11'(11'h100 + i);
      tick();
    end
    n_total++; if ({overflow, count} !== {1'b1, 5'd9}) $display("FAIL pre_flush got=%b/%0d exp=1/9", overflow, count); else n_pass++;
    clr = 1'b1;
    d_in = 11'h3C3;
    tick();
    clr = 1'b0;
    enq = 1'b0;
    n_total++; if (count !== 5'd0) $display("FAIL flush_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (empty_n !== 1'b0) $display("FAIL flush_empty_n got=%b exp=0", empty_n); else n_pass++;
    n_total++; if ({overflow, underflow} !== 2'b00) $display("FAIL flush_errs got=%b%b exp=00", overflow, underflow); else n_pass++;
    enq = 1'b1;
    d_in = 11'h155;
    tick();
    enq = 1'b0;
    n_total++; if ({count, d_out} !== {5'd1, 11'h155}) $display("FAIL post_flush got=%0d/%h exp=1/155", count, d_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    q.delete();
    q.push_back(11'h155);
    for (int i = 0; i < 4; i++) begin
      enq = 1'b1;
      d_in = 11'(11'h040 + i);
      q.push_back(d_in);
      tick();
    end
    enq = 1'b0;
    n_total++; if (count !== 5'd5) $display("FAIL b2b_start got=%0d exp=5", count); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      n_total++; if (d_out !== q[0]) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, d_out, q[0]); else n_pass++;
      enq = 1'b1;
      deq = 1'b1;
      d_in = 11'($urandom_range(0, 2047));
      tick();
      void'(q.pop_front());
      q.push_back(d_in);
      n_total++; if (count !== 5'd5) $display("FAIL b2b_count[%0d] got=%0d exp=5", i, count); else n_pass++;
    end
    enq = 1'b0;
    deq = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      enq = 1'b1;
      d_in = 11'(11'h0E0 + i);
      tick();
    end
    enq = 1'b0;
    n_total++; if (count !== 5'd7) $display("FAIL arst_pre got=%0d exp=7", count); else n_pass++;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++; if (count !== 5'd0) $display("FAIL arst_count got=%0d exp=0", count); else n_pass++;
    n_total++; if ({empty_n, full_n} !== 2'b01) $display("FAIL arst_status got=%b%b exp=01", empty_n, full_n); else n_pass++;
    tick();
    rst_n = 1'b1;
    enq = 1'b1;
    d_in = 11'h0AB;
    tick();
    enq = 1'b0;
    n_total++; if ({count, d_out} !== {5'd1, 11'h0AB}) $display("FAIL arst_resume got=%0d/%h exp=1/0ab", count, d_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
